// File: rtl/fifo_dual_port_queue.sv
// fifo_dual_port_queue: dual-push / dual-pop synchronous FIFO for the fetch/decode queue.
// The two head entries are exposed combinationally for dual-issue decode.
// Pushes and pops are all-or-nothing, judged against the occupancy at the start of the cycle.
// Flush empties the queue in one cycle, for branch redirect.
// Optional feature: define FIFO_ERR_CHK_EN to get sticky overflow/underflow flags;
// without it ErrOvf/ErrUdf are tied low.
module fifo_dual_port_queue #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned AFULL_TH = 14,
  localparam int unsigned AW      = $clog2(DEPTH)
) (
  input  logic              Clk,
  input  logic              Rest,
  input  logic              WrEn0,
  input  logic [WIDTH-1:0]  WrData0,
  input  logic              WrEn1,
  input  logic [WIDTH-1:0]  WrData1,
  output logic              WrReady,
  input  logic              RdEn0,
  input  logic              RdEn1,
  output logic [WIDTH-1:0]  RdData0,
  output logic [WIDTH-1:0]  RdData1,
  output logic              RdValid0,
  output logic              RdValid1,
  input  logic              Flush,
  output logic [AW:0]       Count,
  output logic              Full,
  output logic              Empty,
  output logic              AlmostFull,
  output logic              ErrOvf,
  output logic              ErrUdf
);

  localparam int unsigned CW = AW + 1;

  // Queue storage and registered bookkeeping
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic [AW:0]      count;

  // Per-cycle request decode
  logic [1:0]       n_push;
  logic [1:0]       n_pop;
  logic [AW:0]      free_slots;
  logic             push_ok;
  logic             pop_ok;
  logic [1:0]       n_push_acc;
  logic [1:0]       n_pop_acc;
  logic [AW-1:0]    wptr_p1;
  logic [AW-1:0]    rptr_p1;
  logic [AW:0]      count_nxt;

  // Decode request counts and decide acceptance against start-of-cycle occupancy
  always_comb begin
    n_push     = 2'd0;
    n_pop      = 2'd0;
    free_slots = CW'(DEPTH) - count;
    push_ok    = 1'b0;
    pop_ok     = 1'b0;
    n_push_acc = 2'd0;
    n_pop_acc  = 2'd0;
    wptr_p1    = wptr + AW'(1);
    rptr_p1    = rptr + AW'(1);

    // A lone slot-1 request is illegal and counts as no request
    if (WrEn0) begin
      n_push = WrEn1 ? 2'd2 : 2'd1;
    end
    if (RdEn0) begin
      n_pop = RdEn1 ? 2'd2 : 2'd1;
    end

    // Same-cycle pops do not free space; same-cycle pushes are not readable
    push_ok = (CW'(n_push) <= free_slots);
    pop_ok  = (CW'(n_pop) <= count);

    if (push_ok && !Flush) begin
      n_push_acc = n_push;
    end
    if (pop_ok && !Flush) begin
      n_pop_acc = n_pop;
    end

    count_nxt = count + CW'(n_push_acc) - CW'(n_pop_acc);
  end

  // Pointer and occupancy registers; reset beats flush, flush beats requests
  always_ff @(posedge Clk) begin
    if (Rest) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (Flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      wptr  <= wptr + AW'(n_push_acc);
      rptr  <= rptr + AW'(n_pop_acc);
      count <= count_nxt;
    end
  end

  // Storage write port; contents survive reset and flush but become unreachable
  always_ff @(posedge Clk) begin
    if (!Rest && n_push_acc != 2'd0) begin
      mem[wptr] <= WrData0;
      if (n_push_acc == 2'd2) begin
        mem[wptr_p1] <= WrData1;
      end
    end
  end

  // Head entries and status, all from registered state only
  always_comb begin
    Count      = count;
    Empty      = (count == '0);
    Full       = (count == CW'(DEPTH));
    AlmostFull = (count >= CW'(AFULL_TH));
    WrReady    = (free_slots >= CW'(2));
    RdValid0   = (count >= CW'(1));
    RdValid1   = (count >= CW'(2));
    RdData0    = RdValid0 ? mem[rptr]    : '0;
    RdData1    = RdValid1 ? mem[rptr_p1] : '0;
  end

`ifdef FIFO_ERR_CHK_EN
  logic ovf_evt;
  logic udf_evt;
  logic err_ovf_q;
  logic err_udf_q;

  // Offending requests: rejected transfer or a slot-1 request without slot 0
  always_comb begin
    ovf_evt = !Flush && (!push_ok || (WrEn1 && !WrEn0));
    udf_evt = !Flush && (!pop_ok  || (RdEn1 && !RdEn0));
  end

  // Sticky error flags, cleared only by reset
  always_ff @(posedge Clk) begin
    if (Rest) begin
      err_ovf_q <= 1'b0;
      err_udf_q <= 1'b0;
    end else begin
      if (ovf_evt) begin
        err_ovf_q <= 1'b1;
      end
      if (udf_evt) begin
        err_udf_q <= 1'b1;
      end
    end
  end

  assign ErrOvf = err_ovf_q;
  assign ErrUdf = err_udf_q;
`else
  assign ErrOvf = 1'b0;
  assign ErrUdf = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_dual_port_queue.sv
// Bench for fifo_dual_port_queue: queue-based reference model checked every cycle,
// plus hand-computed expectations along a directed stimulus sequence.
module tb_fifo_dual_port_queue;

  localparam int unsigned WIDTH    = 32;
  localparam int unsigned DEPTH    = 16;
  localparam int unsigned AFULL_TH = 14;
  localparam int unsigned AW       = $clog2(DEPTH);

`ifdef FIFO_ERR_CHK_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic             Clk;
  logic             Rest;
  logic             WrEn0, WrEn1, RdEn0, RdEn1, Flush;
  logic [WIDTH-1:0] WrData0, WrData1;
  logic             WrReady, RdValid0, RdValid1, Full, Empty, AlmostFull, ErrOvf, ErrUdf;
  logic [WIDTH-1:0] RdData0, RdData1;
  logic [AW:0]      Count;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  fifo_dual_port_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AFULL_TH(AFULL_TH)) dut (
    .Clk(Clk), .Rest(Rest),
    .WrEn0(WrEn0), .WrData0(WrData0), .WrEn1(WrEn1), .WrData1(WrData1), .WrReady(WrReady),
    .RdEn0(RdEn0), .RdEn1(RdEn1), .RdData0(RdData0), .RdData1(RdData1),
    .RdValid0(RdValid0), .RdValid1(RdValid1), .Flush(Flush),
    .Count(Count), .Full(Full), .Empty(Empty), .AlmostFull(AlmostFull),
    .ErrOvf(ErrOvf), .ErrUdf(ErrUdf)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got=%0h expected=%0h", nm, $time, act, exp);
    end
  endtask

  // Reference model: the queue contents in order, plus sticky error bits
  logic [WIDTH-1:0] mq[$];
  bit m_ovf = 1'b0;
  bit m_udf = 1'b0;

  always @(posedge Clk) begin
    int np, nr, sz;
    bit wr_bad, rd_bad;
    sz = mq.size();
    np = WrEn0 ? (WrEn1 ? 2 : 1) : 0;
    nr = RdEn0 ? (RdEn1 ? 2 : 1) : 0;
    wr_bad = (WrEn1 && !WrEn0) || (np > int'(DEPTH) - sz);
    rd_bad = (RdEn1 && !RdEn0) || (nr > sz);
    if (Rest) begin
      mq.delete();
      m_ovf = 1'b0;
      m_udf = 1'b0;
    end else if (Flush) begin
      mq.delete();
    end else begin
      if (!rd_bad) begin
        for (int k = 0; k < nr; k++) void'(mq.pop_front());
      end
      if (!wr_bad) begin
        if (np >= 1) mq.push_back(WrData0);
        if (np == 2) mq.push_back(WrData1);
      end
      if (ERR_EN && wr_bad) m_ovf = 1'b1;
      if (ERR_EN && rd_bad) m_udf = 1'b1;
    end
  end

  // Every-cycle comparison of all outputs against the model
  always @(negedge Clk) begin
    if (chk_en) begin
      int sz;
      logic [WIDTH-1:0] e0, e1;
      sz = mq.size();
      e0 = (sz >= 1) ? mq[0] : '0;
      e1 = (sz >= 2) ? mq[1] : '0;
      check("m_count",    64'(Count),      64'(sz));
      check("m_empty",    64'(Empty),      64'(sz == 0));
      check("m_full",     64'(Full),       64'(sz == int'(DEPTH)));
      check("m_afull",    64'(AlmostFull), 64'(sz >= int'(AFULL_TH)));
      check("m_wrready",  64'(WrReady),    64'(int'(DEPTH) - sz >= 2));
      check("m_rdvalid0", 64'(RdValid0),   64'(sz >= 1));
      check("m_rdvalid1", 64'(RdValid1),   64'(sz >= 2));
      check("m_rddata0",  64'(RdData0),    64'(e0));
      check("m_rddata1",  64'(RdData1),    64'(e1));
      check("m_errovf",   64'(ErrOvf),     64'(m_ovf));
      check("m_errudf",   64'(ErrUdf),     64'(m_udf));
    end
  end

  // One clock of stimulus; outputs are stable for sampling on return
  task automatic op(input bit w0, input bit w1, input logic [WIDTH-1:0] d0,
                    input logic [WIDTH-1:0] d1, input bit r0, input bit r1,
                    input bit fl, input bit rs);
    WrEn0 = w0; WrEn1 = w1; WrData0 = d0; WrData1 = d1;
    RdEn0 = r0; RdEn1 = r1; Flush = fl; Rest = rs;
    @(posedge Clk);
    #1;
    WrEn0 = 1'b0; WrEn1 = 1'b0; RdEn0 = 1'b0; RdEn1 = 1'b0; Flush = 1'b0; Rest = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    WrEn0 = 1'b0; WrEn1 = 1'b0; RdEn0 = 1'b0; RdEn1 = 1'b0; Flush = 1'b0;
    WrData0 = '0; WrData1 = '0; Rest = 1'b1;
    repeat (2) @(posedge Clk);
    #1;
    Rest = 1'b0;
    chk_en = 1'b1;

    // Reset state
    check("rst_count",   64'(Count), 64'd0);
    check("rst_empty",   64'(Empty), 64'd1);
    check("rst_full",    64'(Full), 64'd0);
    check("rst_afull",   64'(AlmostFull), 64'd0);
    check("rst_wrready", 64'(WrReady), 64'd1);
    check("rst_rdv0",    64'(RdValid0), 64'd0);
    check("rst_rdd0",    64'(RdData0), 64'd0);
    check("rst_errovf",  64'(ErrOvf), 64'd0);

    // Two dual pushes
    op(1, 1, 32'h11, 32'h22, 0, 0, 0, 0);
    op(1, 1, 32'h33, 32'h44, 0, 0, 0, 0);
    check("dual_count", 64'(Count), 64'd4);
    check("dual_rdd0",  64'(RdData0), 64'h11);
    check("dual_rdd1",  64'(RdData1), 64'h22);
    check("dual_rdv1",  64'(RdValid1), 64'd1);

    // Fill up to 14, then 15
    for (int i = 0; i < 5; i++) op(1, 1, 32'(32'h100 + 2*i), 32'(32'h101 + 2*i), 0, 0, 0, 0);
    check("f14_count", 64'(Count), 64'd14);
    check("f14_afull", 64'(AlmostFull), 64'd1);
    check("f14_wrrdy", 64'(WrReady), 64'd1);
    op(1, 0, 32'h10A, 32'h0, 0, 0, 0, 0);
    check("f15_wrrdy", 64'(WrReady), 64'd0);
    check("f15_full",  64'(Full), 64'd0);

    // Pair push with only one slot free is rejected whole
    op(1, 1, 32'hEE, 32'hEF, 0, 0, 0, 0);
    check("rej_count",  64'(Count), 64'd15);
    check("rej_errovf", 64'(ErrOvf), 64'(ERR_EN));
    check("rej_full",   64'(Full), 64'd0);

    // Full, then push 1 + pop 1: push dropped, pop taken
    op(1, 0, 32'h10B, 32'h0, 0, 0, 0, 0);
    check("full_full", 64'(Full), 64'd1);
    op(1, 0, 32'hDD, 32'h0, 1, 0, 0, 0);
    check("fpp_count", 64'(Count), 64'd15);
    check("fpp_rdd0",  64'(RdData0), 64'h22);
    check("fpp_rdd1",  64'(RdData1), 64'h33);

    // Reset wins over flush and push in the same cycle
    op(1, 0, 32'h55, 32'h0, 0, 0, 1, 1);
    check("rst2_count",  64'(Count), 64'd0);
    check("rst2_errovf", 64'(ErrOvf), 64'd0);

    // Wrap-around: steady-state dual push/pop at occupancy 6
    for (int i = 0; i < 3; i++) op(1, 1, 32'(32'h200 + 2*i), 32'(32'h201 + 2*i), 0, 0, 0, 0);
    for (int i = 0; i < 40; i++) op(1, 1, 32'(32'h300 + 2*i), 32'(32'h301 + 2*i), 1, 1, 0, 0);
    check("wrap_count", 64'(Count), 64'd6);
    check("wrap_rdd0",  64'(RdData0), 64'h34A);
    check("wrap_rdd1",  64'(RdData1), 64'h34B);

    // Flush from occupancy 5 with requests present
    op(0, 0, 32'h0, 32'h0, 1, 0, 0, 0);
    check("pre_fl_count", 64'(Count), 64'd5);
    check("pre_fl_rdd0",  64'(RdData0), 64'h34B);
    op(1, 0, 32'h77, 32'h0, 1, 0, 1, 0);
    check("fl_count",  64'(Count), 64'd0);
    check("fl_empty",  64'(Empty), 64'd1);
    check("fl_rdd0",   64'(RdData0), 64'd0);
    check("fl_errovf", 64'(ErrOvf), 64'd0);
    check("fl_errudf", 64'(ErrUdf), 64'd0);

    // Pop on empty, then illegal lone slot-1 push
    op(0, 0, 32'h0, 32'h0, 1, 0, 0, 0);
    check("udf_count",  64'(Count), 64'd0);
    check("udf_errudf", 64'(ErrUdf), 64'(ERR_EN));
    check("udf_errovf", 64'(ErrOvf), 64'd0);
    op(0, 1, 32'h0, 32'h99, 0, 0, 0, 0);
    check("ilw_count",  64'(Count), 64'd0);
    check("ilw_errovf", 64'(ErrOvf), 64'(ERR_EN));

    // Reset clears the sticky flags
    op(0, 0, 32'h0, 32'h0, 0, 0, 0, 1);
    check("clr_errudf", 64'(ErrUdf), 64'd0);
    check("clr_errovf", 64'(ErrOvf), 64'd0);
    check("clr_count",  64'(Count), 64'd0);

    // Empty with push 1 + pop 1: pop refused, push taken, no bypass
    op(1, 0, 32'hABCD, 32'h0, 1, 0, 0, 0);
    check("epp_count",  64'(Count), 64'd1);
    check("epp_rdd0",   64'(RdData0), 64'hABCD);
    check("epp_errudf", 64'(ErrUdf), 64'(ERR_EN));

    // Illegal lone RdEn1 with data present retires nothing
    op(0, 0, 32'h0, 32'h0, 0, 1, 0, 0);
    check("ilr_count", 64'(Count), 64'd1);

    @(posedge Clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
